// File: rtl/kgp_fetch_pkg.sv
// Shared types and defaults for the KGP-RISC instruction fetch sequencer.
package kgp_fetch_pkg;

  localparam int          KGP_ADDR_W   = 32;
  localparam int          KGP_DATA_W   = 32;
  localparam logic [31:0] KGP_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_STALL = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry holding register for a fetched instruction and its address.
// Only the occupancy flag is reset; the payload is qualified by it.
module fetch_skid_reg
  import kgp_fetch_pkg::*;
#(
  parameter int ADDR_W = KGP_ADDR_W,
  parameter int DATA_W = KGP_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              unload,
  input  logic              flush,
  input  logic [DATA_W-1:0] load_data,
  input  logic [ADDR_W-1:0] load_pc,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] pc,
  output logic              full
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= 1'b0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (unload) begin
      full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      data <= load_data;
      pc   <= load_pc;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// KGP-RISC fetch sequencer: owns the PC, runs the imem req/ack handshake and
// feeds decode. Optional perf counters are enabled with FETCH_PERF_CNT_EN.
module fetch_sequencer
  import kgp_fetch_pkg::*;
#(
  parameter int                ADDR_W   = KGP_ADDR_W,
  parameter int                DATA_W   = KGP_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(KGP_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt, addr_nxt, pc_inc;
  logic              valid_nxt, halt_pending, halt_pend_nxt;
  logic              out_load;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_pc;
  logic              skid_load, skid_unload, skid_flush, skid_full;
  logic [DATA_W-1:0] skid_data;
  logic [ADDR_W-1:0] skid_pc;

  assign pc_inc   = pc + ADDR_W'(1);
  assign imem_req = (state == ST_REQ) || (state == ST_DRAIN);

  fetch_skid_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .unload    (skid_unload),
    .flush     (skid_flush),
    .load_data (imem_rdata),
    .load_pc   (imem_addr),
    .data      (skid_data),
    .pc        (skid_pc),
    .full      (skid_full)
  );

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    addr_nxt      = imem_addr;
    valid_nxt     = instr_valid && !instr_ready;
    halt_pend_nxt = halt_pending;
    out_load      = 1'b0;
    out_data      = imem_rdata;
    out_pc        = imem_addr;
    skid_load     = 1'b0;
    skid_unload   = 1'b0;
    skid_flush    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        state_nxt = ST_REQ;
        addr_nxt  = pc;
        if (halt) begin
          state_nxt     = ST_HALT;
          halt_pend_nxt = 1'b1;
          valid_nxt     = 1'b0;
          skid_flush    = 1'b1;
        end else if (redirect) begin
          pc_nxt     = redirect_pc;
          addr_nxt   = redirect_pc;
          valid_nxt  = 1'b0;
          skid_flush = 1'b1;
        end
      end
      ST_REQ: begin
        if (halt) begin
          halt_pend_nxt = 1'b1;
          valid_nxt     = 1'b0;
          skid_flush    = 1'b1;
          state_nxt     = imem_ack ? ST_HALT : ST_DRAIN;
        end else if (redirect) begin
          pc_nxt     = redirect_pc;
          valid_nxt  = 1'b0;
          skid_flush = 1'b1;
          // A completed request can be replaced at once; an open one must drain.
          if (imem_ack) addr_nxt  = redirect_pc;
          else          state_nxt = ST_DRAIN;
        end else if (imem_ack) begin
          pc_nxt   = pc_inc;
          addr_nxt = pc_inc;
          if (!instr_valid || instr_ready) begin
            out_load  = 1'b1;
            valid_nxt = 1'b1;
          end else begin
            skid_load = 1'b1;
            state_nxt = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        if (halt) begin
          halt_pend_nxt = 1'b1;
          valid_nxt     = 1'b0;
          skid_flush    = 1'b1;
          state_nxt     = ST_HALT;
        end else if (redirect) begin
          pc_nxt     = redirect_pc;
          addr_nxt   = redirect_pc;
          valid_nxt  = 1'b0;
          skid_flush = 1'b1;
          state_nxt  = ST_REQ;
        end else if (instr_ready) begin
          out_load    = 1'b1;
          out_data    = skid_data;
          out_pc      = skid_pc;
          valid_nxt   = skid_full;
          skid_unload = 1'b1;
          addr_nxt    = pc;
          state_nxt   = ST_REQ;
        end
      end
      ST_DRAIN: begin
        // imem_addr is held until the abandoned request is acked; its data is discarded.
        if (halt) begin
          halt_pend_nxt = 1'b1;
          valid_nxt     = 1'b0;
          skid_flush    = 1'b1;
        end else if (redirect && !halt_pending) begin
          pc_nxt     = redirect_pc;
          valid_nxt  = 1'b0;
          skid_flush = 1'b1;
        end
        if (imem_ack) begin
          if (halt || halt_pending) begin
            state_nxt = ST_HALT;
          end else begin
            state_nxt = ST_REQ;
            addr_nxt  = pc_nxt;
          end
        end
      end
      ST_HALT: begin
        valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = ST_IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      pc           <= RESET_PC;
      imem_addr    <= RESET_PC;
      instr        <= '0;
      instr_pc     <= '0;
      instr_valid  <= 1'b0;
      halt_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      imem_addr    <= addr_nxt;
      instr_valid  <= valid_nxt;
      halt_pending <= halt_pend_nxt;
      if (out_load) begin
        instr    <= out_data;
        instr_pc <= out_pc;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (instr_valid && instr_ready && !redirect && !halt)
        perf_fetched <= sat_inc(perf_fetched);
      if ((state == ST_REQ && !imem_ack) || state == ST_STALL || state == ST_DRAIN)
        perf_stall <= sat_inc(perf_stall);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table, directed corner cases
// and a randomized run checked against an in-order instruction stream model.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  fetch_sequencer #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .pc          (pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Instruction memory: acks after mem_lat waiting cycles (mem_lat < 0: random 0..3).
  int mem_lat  = 0;
  int cur_lat  = 0;
  int mem_wait = 0;
  always @(posedge clk) begin
    #1;
    if (!rst || !imem_req) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      mem_wait   = 0;
      cur_lat    = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
    end else if (mem_wait >= cur_lat) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_f(imem_addr);
      mem_wait   = 0;
      cur_lat    = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      mem_wait++;
    end
  end

  // Reference model: decode must see consecutive addresses, restarting at each redirect.
  logic [31:0] exp_pc;
  int          acc_cnt;
  logic        prev_req, prev_ack;
  logic [31:0] prev_addr;
  always @(negedge clk) begin
    if (!rst) begin
      exp_pc   = 32'h0;
      acc_cnt  = 0;
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (prev_req && !prev_ack && imem_req)
        chk("addr_hold", imem_addr, prev_addr);
      if (halt) begin
      end else if (redirect) begin
        exp_pc = redirect_pc;
      end else if (instr_valid && instr_ready) begin
        chk("stream_pc", instr_pc, exp_pc);
        chk("stream_data", instr, mem_f(exp_pc));
        exp_pc = exp_pc + 32'd1;
        acc_cnt++;
      end
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
    end
  end

  task automatic do_reset();
    redirect = 1'b0;
    halt     = 1'b0;
    rst      = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  typedef struct {
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ipc;
    logic [31:0] pcv;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic        found;
    logic [31:0] pc_before;

    rst = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;

    tbl[0]  = '{1'b1, 1'b1, 32'd0, 1'b0, 32'd0, 32'd0};
    tbl[1]  = '{1'b1, 1'b1, 32'd1, 1'b1, 32'd0, 32'd1};
    tbl[2]  = '{1'b1, 1'b1, 32'd2, 1'b1, 32'd1, 32'd2};
    tbl[3]  = '{1'b1, 1'b1, 32'd3, 1'b1, 32'd2, 32'd3};
    tbl[4]  = '{1'b1, 1'b1, 32'd4, 1'b1, 32'd3, 32'd4};
    tbl[5]  = '{1'b0, 1'b1, 32'd5, 1'b1, 32'd4, 32'd5};
    tbl[6]  = '{1'b0, 1'b0, 32'd6, 1'b1, 32'd4, 32'd6};
    tbl[7]  = '{1'b0, 1'b0, 32'd6, 1'b1, 32'd4, 32'd6};
    tbl[8]  = '{1'b0, 1'b0, 32'd6, 1'b1, 32'd4, 32'd6};
    tbl[9]  = '{1'b1, 1'b0, 32'd6, 1'b1, 32'd4, 32'd6};
    tbl[10] = '{1'b1, 1'b1, 32'd6, 1'b1, 32'd5, 32'd6};
    tbl[11] = '{1'b1, 1'b1, 32'd7, 1'b1, 32'd6, 32'd7};
    tbl[12] = '{1'b1, 1'b1, 32'd8, 1'b1, 32'd7, 32'd8};

    // Reset state
    mem_lat = 0;
    step();
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_pc", pc, 32'd0);
    rst = 1'b1;
    instr_ready = 1'b1;

    // Streaming and output back-pressure into the skid
    for (int i = 0; i < 13; i++) begin
      step();
      instr_ready = tbl[i].ready;
      chk($sformatf("tbl%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].req});
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].valid});
      chk($sformatf("tbl%0d_instr_pc", i), instr_pc, tbl[i].ipc);
      chk($sformatf("tbl%0d_instr", i), instr, tbl[i].valid ? mem_f(tbl[i].ipc) : 32'd0);
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].pcv);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("tbl_perf_fetched", perf_fetched, 32'd7);
    chk("tbl_perf_stall", perf_stall, 32'd4);
`endif

    // Redirect while the request for address 7 is outstanding
    mem_lat = 3;
    instr_ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (imem_req && imem_addr == 32'd7) found = 1'b1;
    end
    chk("wait_addr7", {31'd0, found}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    chk("drain_req", {31'd0, imem_req}, 32'd1);
    chk("drain_addr", imem_addr, 32'd7);
    chk("drain_pc", pc, 32'h40);
    chk("drain_valid", {31'd0, instr_valid}, 32'd0);
    step();
    step();
    chk("drain_addr_late", imem_addr, 32'd7);
    step();
    chk("post_drain_req", {31'd0, imem_req}, 32'd1);
    chk("post_drain_addr", imem_addr, 32'h40);
    chk("post_drain_valid", {31'd0, instr_valid}, 32'd0);
    for (int i = 0; i < 12; i++) step();

    // Redirect coinciding with an ack
    mem_lat = 0;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    chk("pre_redir_ack", {31'd0, imem_ack}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h10;
    step();
    redirect = 1'b0;
    chk("redir_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir_ack_addr", imem_addr, 32'h10);
    chk("redir_ack_pc", pc, 32'h10);
    step();
    chk("redir_ack_first_valid", {31'd0, instr_valid}, 32'd1);
    chk("redir_ack_first_pc", instr_pc, 32'h10);
    chk("redir_ack_first_instr", instr, mem_f(32'h10));

    // Address wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    chk("wrap_addr_hi", imem_addr, 32'hFFFF_FFFF);
    step();
    chk("wrap_addr_lo", imem_addr, 32'h0);
    chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFF);
    chk("wrap_pc", pc, 32'h0);
    step();

    // Halt with an outstanding request and a simultaneous redirect
    mem_lat = 2;
    do_reset();
    for (int i = 0; i < 6; i++) step();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_req && !imem_ack) found = 1'b1;
      else step();
    end
    chk("wait_outstanding", {31'd0, found}, 32'd1);
    pc_before = pc;
    halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h99;
    step();
    halt = 1'b0; redirect = 1'b0;
    chk("halt_drain_req", {31'd0, imem_req}, 32'd1);
    chk("halt_drain_valid", {31'd0, instr_valid}, 32'd0);
    chk("halt_drain_pc", pc, pc_before);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (!imem_req) found = 1'b1;
    end
    chk("halt_reached", {31'd0, found}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      redirect = $urandom_range(0, 1) == 1; redirect_pc = $urandom;
      halt = $urandom_range(0, 3) == 0;
      step();
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_pc", pc, pc_before);
    end
    redirect = 1'b0; halt = 1'b0;
    mem_lat = 0;
    do_reset();
    step();
    chk("halt_exit_req", {31'd0, imem_req}, 32'd1);
    chk("halt_exit_addr", imem_addr, 32'd0);

    // Randomized traffic against the stream model
    mem_lat = -1;
    do_reset();
    step();
    step();
    for (int i = 0; i < 1500; i++) begin
      instr_ready = $urandom_range(0, 2) != 0;
      redirect    = $urandom_range(0, 19) == 0;
      redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE - $urandom_range(0, 3) : $urandom;
      step();
    end
    redirect = 1'b0;
    instr_ready = 1'b1;
    step();
    chk("rand_progress", 32'(acc_cnt >= 100), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("rand_perf_fetched", perf_fetched, 32'(acc_cnt));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls instruction fetch for the KGP-RISC core.
- Owns the PC. Issues word addresses to instruction memory over a req/ack handshake with variable latency, and delivers fetched instructions to decode over a valid/ready handshake.
- Handles branch/jump redirects (flush plus drop of in-flight data) and halt.
- Replaces the free-running pc+1 loop around the instruction fetcher and program counter.

Parameters:
- ADDR_W, 32, PC / instruction-memory address width (word-addressed).
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held high until imem_ack.
- imem_addr  out  ADDR_W  fetch word address; stable while imem_req=1.
- imem_ack  in  1  one-cycle pulse: imem_rdata valid, request complete.
- imem_rdata  in  DATA_W  fetched instruction.
- instr  out  DATA_W  instruction to decode.
- instr_pc  out  ADDR_W  address of instr.
- instr_valid  out  1  instr/instr_pc valid.
- instr_ready  in  1  decode accepts instr this cycle.
- redirect  in  1  one-cycle pulse: taken branch/jump.
- redirect_pc  in  ADDR_W  new fetch address, valid with redirect.
- halt  in  1  one-cycle pulse: halt decoded.
- pc  out  ADDR_W  next address to fetch (architectural fetch PC).

Behaviour:
- Reset (rst=0, async) forces:
  - state=IDLE, pc=RESET_PC;
  - imem_req=0, imem_addr=RESET_PC;
  - instr=0, instr_pc=0, instr_valid=0;
  - skid empty, halt_pending=0.
- States: IDLE, REQ, STALL, DRAIN, HALT. imem_req=1 only in REQ and DRAIN. imem_addr is registered.
- IDLE: next cycle go to REQ with imem_addr=pc.
- REQ, handling imem_ack:
  - Output slot free (instr_valid=0 or instr_ready=1): load instr=imem_rdata, instr_pc=imem_addr, instr_valid=1; pc and imem_addr advance to pc+1; stay in REQ (back-to-back request next cycle).
  - Output slot occupied and not consumed: store imem_rdata and imem_addr in the one-entry skid; pc advances to pc+1; go to STALL.
- STALL: imem_req=0. On instr_ready, move skid into the output (instr_valid stays 1), then go to REQ.
- Consumption: instr_valid && instr_ready with no new load clears instr_valid.
- Best-case throughput: 1 instruction/cycle when ack is combinational-next-cycle. Minimum latency from req to instr_valid is 1 cycle after ack.
- Redirect (priority over ack and ready; ignored in HALT):
  - Next cycle: instr_valid=0, skid emptied, pc=redirect_pc. Any instr_ready in the same cycle is a no-op.
  - In REQ with imem_ack the same cycle: data dropped; go to REQ with imem_addr=redirect_pc.
  - In REQ without ack: a request is outstanding. Go to DRAIN; imem_req and the old imem_addr are held until ack, the data is discarded, then go to REQ at pc.
  - In DRAIN: pc updated to the new redirect_pc; stay in DRAIN.
  - In IDLE or STALL: go to REQ at redirect_pc.
- Halt (priority over redirect when both are asserted):
  - Flush exactly as a redirect, but pc is unchanged and halt_pending=1.
  - With an outstanding request: go to DRAIN, then HALT after the ack. Otherwise go straight to HALT.
- HALT: imem_req=0, instr_valid=0. Exited only by reset; redirect and halt are ignored.
- PC arithmetic: pc+1 modulo 2^ADDR_W. Wrap from all-ones to 0 is silent.
- imem_ack outside REQ/DRAIN is illegal and ignored.
- Reset mid-request: the request is abandoned; the memory side must tolerate imem_req dropping.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32, out) and perf_stall (32, out).
  - perf_fetched increments on each instr_valid && instr_ready with no redirect or halt that cycle.
  - perf_stall increments each cycle in REQ with no ack, in STALL, or in DRAIN.
  - Both reset to 0 and saturate at all-ones.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package kgp_fetch_pkg holds:
  - the state encoding constants (IDLE=0, REQ=1, STALL=2, DRAIN=3, HALT=4, 3-bit);
  - default ADDR_W/DATA_W;
  - RESET_PC.
- One sub-module: fetch_skid_reg, a one-entry data+pc holding register with load, unload and flush, reset empty.
- FSM, PC and output register stay in fetch_sequencer.

Test Plan:
- Reset release with RESET_PC=0, ack one cycle after each req, instr_ready=1 → imem_addr 0,1,2,3 on consecutive requests; instr_pc 0,1,2,3; one instruction per cycle after the first.
- instr_ready=0 for 4 cycles while fetching → one ack captured in output, next ack into skid, state STALL, imem_req=0. On ready, instr_pc 5 then 6 delivered in order, no loss or duplication.
- redirect with redirect_pc=0x40 while a request for addr 7 is outstanding (ack 3 cycles later) → imem_addr stays 7 until ack, addr-7 data never appears on instr, next request is 0x40.
- redirect and imem_ack in the same cycle, redirect_pc=0x10 → acked data dropped, instr_valid=0 next cycle, next imem_addr=0x10.
- halt with an outstanding request, plus a simultaneous redirect → DRAIN then HALT, pc unchanged, imem_req stays 0 thereafter, later redirects ignored until rst pulsed low.
- pc=0xFFFFFFFF fetched → next imem_addr=0x00000000. With FETCH_PERF_CNT_EN, perf_fetched equals the count of accepted instructions.
